// File: rtl/race_pkg.sv
// Shared screen codes, controller states and sizing helpers for the LED racer.
package race_pkg;

    localparam logic [1:0] SCREEN_MENU      = 2'b00;
    localparam logic [1:0] SCREEN_GAME      = 2'b01;
    localparam logic [1:0] SCREEN_END       = 2'b10;
    localparam logic [1:0] SCREEN_COUNTDOWN = 2'b11;

    typedef enum logic [2:0] {
        ST_MENU,
        ST_LOBBY,
        ST_COUNTDOWN,
        ST_GAME,
        ST_END,
        ST_CLEAR
    } raceState_e;

    function automatic int posWidth(input int maxPos);
        return (maxPos > 2) ? $clog2(maxPos) : 1;
    endfunction

    function automatic int idWidth(input int nbPlayers);
        return (nbPlayers > 2) ? $clog2(nbPlayers) : 1;
    endfunction

    // One spare bit above the largest load value keeps every tick count representable.
    function automatic int timerWidth(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/race_tick_timer.sv
// Loadable down-counter; a load of N raises done on the Nth enabled cycle.
module race_tick_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [TW-1:0] value_i,
    input  logic          enable_i,
    output logic          done_o
);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (enable_i && count_q != '0) begin
            count_q <= count_q - TW'(1);
        end
    end

    assign done_o = (count_q == TW'(1));

endmodule

// File: rtl/race_game_controller.sv
// Central sequencer: menu/lobby, countdown, race, winner display and player clear.
module race_game_controller
    import race_pkg::*;
#(
    parameter int NB_PLAYERS  = 4,
    parameter int MAX_POS     = 16,
    parameter int LOBBY_TICKS = 150000000,
    parameter int STEP_TICKS  = 50000000,
    parameter int END_TICKS   = 250000000,
    parameter int IDLE_TICKS  = 1500000000,
    localparam int PW = posWidth(MAX_POS),
    localparam int WW = idWidth(NB_PLAYERS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NB_PLAYERS-1:0]    ready_mask,
    input  logic [NB_PLAYERS-1:0]    activity_mask,
    input  logic [NB_PLAYERS*PW-1:0] pos_flat,
    output logic [1:0]               current_screen,
    output logic                     players_reset,
    output logic [1:0]               countdown,
    output logic                     winner_valid,
    output logic [WW-1:0]            winner_id
);

    localparam int TW = timerWidth(LOBBY_TICKS, STEP_TICKS, END_TICKS, IDLE_TICKS);
    localparam logic [PW-1:0] FINISH_POS = PW'(MAX_POS - 1);

    raceState_e    state_q;
    logic [1:0]    screen_q;
    logic          playersReset_q;
    logic [1:0]    countdown_q;
    logic          winnerValid_q;
    logic [WW-1:0] winnerId_q;

    logic          anyHit;
    logic [WW-1:0] hitId;
    logic          anyActivity;
    logic          phaseLoad, phaseEnable, phaseDone;
    logic [TW-1:0] phaseValue;
    logic          idleLoad, idleEnable, idleDone;

    assign anyActivity = |activity_mask;

    // Descending scan so the lowest finishing index is the one left standing.
    always_comb begin
        anyHit = 1'b0;
        hitId  = '0;
        for (int i = NB_PLAYERS - 1; i >= 0; i--) begin
            if (ready_mask[i] && pos_flat[i*PW +: PW] == FINISH_POS) begin
                anyHit = 1'b1;
                hitId  = WW'(i);
            end
        end
    end

    always_comb begin
        phaseLoad   = 1'b0;
        phaseValue  = TW'(STEP_TICKS);
        phaseEnable = 1'b0;
        idleLoad    = 1'b0;
        idleEnable  = 1'b0;
        case (state_q)
            ST_MENU: begin
                if (|ready_mask) begin
                    phaseLoad  = 1'b1;
                    phaseValue = TW'(LOBBY_TICKS);
                    idleLoad   = 1'b1;
                end
            end
            ST_LOBBY: begin
                phaseEnable = 1'b1;
                idleEnable  = 1'b1;
                phaseLoad   = phaseDone;
                idleLoad    = anyActivity;
            end
            ST_COUNTDOWN: begin
                phaseEnable = 1'b1;
                if (phaseDone) begin
                    if (countdown_q == 2'd1) idleLoad  = 1'b1;
                    else                     phaseLoad = 1'b1;
                end
            end
            ST_GAME: begin
                idleEnable = 1'b1;
                idleLoad   = anyActivity;
                if (anyHit) begin
                    phaseLoad  = 1'b1;
                    phaseValue = TW'(END_TICKS);
                end
            end
            ST_END: phaseEnable = 1'b1;
            default: ;
        endcase
    end

    race_tick_timer #(.TW(TW)) phaseTimer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (phaseLoad),
        .value_i  (phaseValue),
        .enable_i (phaseEnable),
        .done_o   (phaseDone)
    );

    race_tick_timer #(.TW(TW)) idleTimer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (idleLoad),
        .value_i  (TW'(IDLE_TICKS)),
        .enable_i (idleEnable),
        .done_o   (idleDone)
    );

    // A finish always beats an idle abort arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_MENU;
            screen_q       <= SCREEN_MENU;
            playersReset_q <= 1'b0;
            countdown_q    <= 2'd0;
            winnerValid_q  <= 1'b0;
            winnerId_q     <= '0;
        end else begin
            playersReset_q <= 1'b0;
            case (state_q)
                ST_MENU: begin
                    if (|ready_mask) begin
                        state_q  <= ST_LOBBY;
                        screen_q <= SCREEN_MENU;
                    end
                end
                ST_LOBBY: begin
                    if (ready_mask == '0) begin
                        state_q <= ST_MENU;
                    end else if (phaseDone) begin
                        state_q     <= ST_COUNTDOWN;
                        screen_q    <= SCREEN_COUNTDOWN;
                        countdown_q <= 2'd3;
                    end else if (!anyActivity && idleDone) begin
                        state_q        <= ST_CLEAR;
                        screen_q       <= SCREEN_END;
                        playersReset_q <= 1'b1;
                    end
                end
                ST_COUNTDOWN: begin
                    if (phaseDone) begin
                        countdown_q <= countdown_q - 2'd1;
                        if (countdown_q == 2'd1) begin
                            state_q  <= ST_GAME;
                            screen_q <= SCREEN_GAME;
                        end
                    end
                end
                ST_GAME: begin
                    if (anyHit) begin
                        state_q       <= ST_END;
                        screen_q      <= SCREEN_END;
                        winnerValid_q <= 1'b1;
                        winnerId_q    <= hitId;
                    end else if (!anyActivity && idleDone) begin
                        state_q        <= ST_CLEAR;
                        screen_q       <= SCREEN_END;
                        playersReset_q <= 1'b1;
                    end
                end
                ST_END: begin
                    if (phaseDone) begin
                        state_q        <= ST_CLEAR;
                        playersReset_q <= 1'b1;
                        winnerValid_q  <= 1'b0;
                        winnerId_q     <= '0;
                    end
                end
                default: begin
                    state_q  <= ST_MENU;
                    screen_q <= SCREEN_MENU;
                end
            endcase
        end
    end

    assign current_screen = screen_q;
    assign players_reset  = playersReset_q;
    assign countdown      = countdown_q;
    assign winner_valid   = winnerValid_q;
    assign winner_id      = winnerId_q;

endmodule

// File: tb/tb_race_game_controller.sv
// Directed scenarios plus randomized traffic, all checked against a cycle-level behavioural model.
module tb_race_game_controller;

    localparam int NP = 4;
    localparam int MP = 16;
    localparam int LT = 4;
    localparam int ST = 3;
    localparam int ET = 5;
    localparam int IT = 20;

    localparam int M_MENU  = 0;
    localparam int M_LOBBY = 1;
    localparam int M_CD    = 2;
    localparam int M_GAME  = 3;
    localparam int M_END   = 4;
    localparam int M_CLEAR = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  readyMask = '0;
    logic [3:0]  activityMask = '0;
    logic [15:0] posFlat = '0;
    logic [1:0]  screen;
    logic        playersReset;
    logic [1:0]  countdown;
    logic        winnerValid;
    logic [1:0]  winnerId;

    int checks = 0;
    int failures = 0;

    int mMode = M_MENU;
    int mPhaseLeft = 0;
    int mIdleLeft = 0;
    int mCd = 0;
    int mWid = 0;
    bit mWv = 0;
    bit mPr = 0;
    bit modelArmed = 0;

    always #5 clk = ~clk;

    race_game_controller #(
        .NB_PLAYERS  (NP),
        .MAX_POS     (MP),
        .LOBBY_TICKS (LT),
        .STEP_TICKS  (ST),
        .END_TICKS   (ET),
        .IDLE_TICKS  (IT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ready_mask     (readyMask),
        .activity_mask  (activityMask),
        .pos_flat       (posFlat),
        .current_screen (screen),
        .players_reset  (playersReset),
        .countdown      (countdown),
        .winner_valid   (winnerValid),
        .winner_id      (winnerId)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic logic [1:0] modelScreen();
        case (mMode)
            M_CD:    return 2'b11;
            M_GAME:  return 2'b01;
            M_END:   return 2'b10;
            M_CLEAR: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic enterClear();
        mMode = M_CLEAR;
        mPr   = 1;
        mWv   = 0;
        mWid  = 0;
    endtask

    // One clock of the game rules: phases last a fixed number of cycles, idle counts silent cycles.
    task automatic modelStep();
        int win;
        if (reset) begin
            mMode = M_MENU; mPhaseLeft = 0; mIdleLeft = 0;
            mCd = 0; mWv = 0; mWid = 0; mPr = 0;
            modelArmed = 1;
        end else if (modelArmed) begin
            mPr = 0;
            case (mMode)
                M_MENU: begin
                    if (readyMask != 0) begin
                        mMode = M_LOBBY; mPhaseLeft = LT; mIdleLeft = IT;
                    end
                end
                M_LOBBY: begin
                    mPhaseLeft--;
                    mIdleLeft = (activityMask != 0) ? IT : mIdleLeft - 1;
                    if (readyMask == 0) mMode = M_MENU;
                    else if (mPhaseLeft == 0) begin
                        mMode = M_CD; mCd = 3; mPhaseLeft = ST;
                    end else if (mIdleLeft == 0) enterClear();
                end
                M_CD: begin
                    mPhaseLeft--;
                    if (mPhaseLeft == 0) begin
                        if (mCd == 1) begin
                            mMode = M_GAME; mCd = 0; mIdleLeft = IT;
                        end else begin
                            mCd--; mPhaseLeft = ST;
                        end
                    end
                end
                M_GAME: begin
                    win = -1;
                    for (int i = 0; i < NP; i++)
                        if (win < 0 && readyMask[i] && posFlat[i*4 +: 4] == 4'(MP - 1)) win = i;
                    if (win >= 0) begin
                        mMode = M_END; mWv = 1; mWid = win; mPhaseLeft = ET;
                    end else begin
                        mIdleLeft = (activityMask != 0) ? IT : mIdleLeft - 1;
                        if (mIdleLeft == 0) enterClear();
                    end
                end
                M_END: begin
                    mPhaseLeft--;
                    if (mPhaseLeft == 0) enterClear();
                end
                default: mMode = M_MENU;
            endcase
        end
    endtask

    // Model advances on each rising edge; outputs are compared just after it.
    always begin
        @(posedge clk);
        modelStep();
        #1;
        if (modelArmed) begin
            checkOutput("model.screen", screen, modelScreen());
            checkOutput("model.countdown", countdown, mCd);
            checkOutput("model.winner_valid", winnerValid, mWv);
            checkOutput("model.winner_id", winnerId, mWid);
            checkOutput("model.players_reset", playersReset, mPr);
        end
    end

    task automatic applyStimulus(input logic [3:0] rdy, input logic [3:0] act, input logic [15:0] pos);
        readyMask    = rdy;
        activityMask = act;
        posFlat      = pos;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitScreen(input logic [1:0] s, input int limit, input string name);
        int n;
        n = 0;
        while (screen !== s && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, screen, s);
    endtask

    task automatic goToGame(input logic [3:0] rdy);
        applyStimulus(rdy, 4'b1111, 16'h0000);
        waitScreen(2'b01, 40, "reachGame");
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".screen"}, screen, 0);
        checkOutput({tag, ".countdown"}, countdown, 0);
        checkOutput({tag, ".winner_valid"}, winnerValid, 0);
        checkOutput({tag, ".winner_id"}, winnerId, 0);
        checkOutput({tag, ".players_reset"}, playersReset, 0);
    endtask

    initial begin
        logic [3:0]  rdy, act;
        logic [15:0] pos;
        bit quiet;

        stepCycles(2);
        checkResetValues("reset");
        reset = 1'b0;

        // Lobby of 4 cycles, then 3 countdown steps of 3 cycles each.
        applyStimulus(4'b0001, 4'b0000, 16'h0000);
        stepCycles(1); checkOutput("lobby.screen", screen, 0);
        stepCycles(3); checkOutput("lobbyEnd.screen", screen, 0);
        stepCycles(1); checkOutput("cd.screen", screen, 3); checkOutput("cd3", countdown, 3);
        stepCycles(2); checkOutput("cd3.hold", countdown, 3);
        stepCycles(1); checkOutput("cd2", countdown, 2);
        stepCycles(3); checkOutput("cd1", countdown, 1);
        stepCycles(2); checkOutput("cdLast.screen", screen, 3);
        stepCycles(1); checkOutput("game.screen", screen, 1); checkOutput("game.countdown", countdown, 0);

        // Player 2 finishes; winner held for 5 cycles then one clear cycle.
        applyStimulus(4'b0100, 4'b0000, 16'h0F00);
        stepCycles(1);
        checkOutput("win2.screen", screen, 2);
        checkOutput("win2.valid", winnerValid, 1);
        checkOutput("win2.id", winnerId, 2);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        stepCycles(4); checkOutput("endHold.valid", winnerValid, 1); checkOutput("endHold.pr", playersReset, 0);
        stepCycles(1); checkOutput("clear.pr", playersReset, 1); checkOutput("clear.valid", winnerValid, 0);
        checkOutput("clear.screen", screen, 2);
        stepCycles(1); checkOutput("menu.screen", screen, 0); checkOutput("menu.pr", playersReset, 0);

        // Simultaneous finish of players 1 and 3.
        goToGame(4'b0001);
        applyStimulus(4'b1010, 4'b0000, 16'hF0F0);
        stepCycles(1);
        checkOutput("tie.valid", winnerValid, 1);
        checkOutput("tie.id", winnerId, 1);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        waitScreen(2'b00, 20, "tie.backToMenu");

        // Finish position from a player who is not ready is ignored.
        goToGame(4'b0001);
        applyStimulus(4'b1110, 4'b1111, 16'h000F);
        stepCycles(3);
        checkOutput("notReady.screen", screen, 1);
        checkOutput("notReady.valid", winnerValid, 0);

        // Idle: activity on the 19th silent cycle rescues, 20 silent cycles abort.
        applyStimulus(4'b1110, 4'b0000, 16'h0000);
        stepCycles(18); checkOutput("idle18.screen", screen, 1);
        applyStimulus(4'b1110, 4'b0001, 16'h0000);
        stepCycles(1);
        applyStimulus(4'b1110, 4'b0000, 16'h0000);
        stepCycles(19); checkOutput("idle19.screen", screen, 1);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        stepCycles(1);
        checkOutput("abort.screen", screen, 2);
        checkOutput("abort.pr", playersReset, 1);
        checkOutput("abort.valid", winnerValid, 0);
        stepCycles(1); checkOutput("abort.menu", screen, 0);

        // Reset in the middle of countdown and of the winner screen.
        applyStimulus(4'b0001, 4'b0000, 16'h0000);
        waitScreen(2'b11, 20, "reachCountdown");
        stepCycles(1);
        reset = 1'b1;
        stepCycles(1);
        checkResetValues("resetCd");
        reset = 1'b0;
        goToGame(4'b0001);
        applyStimulus(4'b0001, 4'b0000, 16'h000F);
        stepCycles(1); checkOutput("preResetEnd.screen", screen, 2);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        stepCycles(2);
        reset = 1'b1;
        stepCycles(1);
        checkResetValues("resetEnd");
        reset = 1'b0;

        // Randomized traffic shaped by the current game phase.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(399) == 0);
            quiet = ((c % 250) < 70);
            act = (!quiet && $urandom_range(5) == 0) ? 4'($urandom) : 4'b0000;
            case (mMode)
                M_MENU:  rdy = ($urandom_range(3) == 0) ? 4'($urandom_range(15, 1)) : 4'b0000;
                M_LOBBY: rdy = ($urandom_range(29) == 0) ? 4'b0000 : 4'($urandom_range(15, 1));
                M_CLEAR: rdy = 4'b0000;
                default: rdy = 4'($urandom);
            endcase
            for (int p = 0; p < NP; p++)
                pos[p*4 +: 4] = ($urandom_range(39) == 0) ? 4'd15 : 4'($urandom_range(14));
            applyStimulus(rdy, act, pos);
        end
        @(negedge clk);
        reset = 1'b0;
        stepCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
